// File: rtl/fu_mul_arbiter.sv
// Round-robin arbiter sharing one non-pipelined multiplier among NREQ issue sources,
// holding each result for the CDB. Define FU_MUL_ARB_OVERLAP_EN to issue while a result waits.
module fu_mul_arbiter #(
    parameter int NREQ = 4,
    parameter int TAGW = 5,
    parameter int LAT  = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*32-1:0]   req_a,
    input  logic [NREQ*32-1:0]   req_b,
    input  logic [NREQ*TAGW-1:0] req_tag,
    output logic                 fu_en,
    output logic [31:0]          fu_a,
    output logic [31:0]          fu_b,
    input  logic [31:0]          fu_res,
    input  logic                 fu_finish,
    output logic                 cdb_valid,
    input  logic                 cdb_ready,
    output logic [31:0]          cdb_data,
    output logic [TAGW-1:0]      cdb_tag,
    output logic                 busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(LAT + 2);

    typedef enum logic [1:0] {DRAIN, IDLE, WAIT, DONE} state_t;

    state_t          state_reg;
    logic [CW-1:0]   drain_cnt_reg;
    logic [PW-1:0]   rr_ptr_reg;
    logic [TAGW-1:0] tag_reg;
    logic            cdb_valid_reg;
    logic [31:0]     cdb_data_reg;
    logic [TAGW-1:0] cdb_tag_reg;
    logic            busy_reg;
    logic            res_pending_reg;

    logic [31:0]     a_arr   [NREQ];
    logic [31:0]     b_arr   [NREQ];
    logic [TAGW-1:0] tag_arr [NREQ];
    logic [PW-1:0]   cand_idx [NREQ];

    logic [PW-1:0]   grant_idx;
    logic            grant_any;
    logic            can_grant;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
        assign a_arr[gi]    = req_a[32*gi +: 32];
        assign b_arr[gi]    = req_b[32*gi +: 32];
        assign tag_arr[gi]  = req_tag[TAGW*gi +: TAGW];
        // cand_idx[k] is the k-th index in round-robin search order after rr_ptr
        assign cand_idx[gi] = PW'((int'(rr_ptr_reg) + gi + 1) % NREQ);
        assign req_ready[gi] = fu_en && (grant_idx == PW'(gi));
    end

    // Walk the search order backwards so the earliest valid candidate wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[cand_idx[k]]) begin
                grant_any = 1'b1;
                grant_idx = cand_idx[k];
            end
        end
    end

`ifdef FU_MUL_ARB_OVERLAP_EN
    assign can_grant = (state_reg == IDLE) ||
                       ((state_reg == DONE) && !cdb_ready && !res_pending_reg);
`else
    assign can_grant = (state_reg == IDLE) && !res_pending_reg;
`endif

    assign fu_en = can_grant && grant_any;
    assign fu_a  = fu_en ? a_arr[grant_idx] : 32'd0;
    assign fu_b  = fu_en ? b_arr[grant_idx] : 32'd0;

    assign cdb_valid = cdb_valid_reg;
    assign cdb_data  = cdb_data_reg;
    assign cdb_tag   = cdb_tag_reg;
    assign busy      = busy_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= DRAIN;
            drain_cnt_reg   <= CW'(LAT + 1);
            cdb_valid_reg   <= 1'b0;
            cdb_data_reg    <= '0;
            cdb_tag_reg     <= '0;
            rr_ptr_reg      <= PW'(NREQ - 1);
            res_pending_reg <= 1'b0;
            busy_reg        <= 1'b1;
            tag_reg         <= '0;
        end else begin
            if (fu_en) begin
                rr_ptr_reg <= grant_idx;
                tag_reg    <= tag_arr[grant_idx];
            end
            case (state_reg)
                // The FU has no reset; let any op issued before reset run out.
                DRAIN: begin
                    drain_cnt_reg <= drain_cnt_reg - CW'(1);
                    if (drain_cnt_reg <= CW'(1)) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                IDLE: begin
                    if (fu_en) begin
                        state_reg <= WAIT;
                        busy_reg  <= 1'b1;
                    end
                end
                WAIT: begin
`ifdef FU_MUL_ARB_OVERLAP_EN
                    if (cdb_valid_reg && cdb_ready && !fu_finish)
                        cdb_valid_reg <= 1'b0;
                    if (fu_finish) begin
                        state_reg <= DONE;
                        if (cdb_valid_reg && !cdb_ready) begin
                            // Register still occupied: fu_res stays stable, load later.
                            res_pending_reg <= 1'b1;
                        end else begin
                            cdb_valid_reg <= 1'b1;
                            cdb_data_reg  <= fu_res;
                            cdb_tag_reg   <= tag_reg;
                        end
                    end
`else
                    if (fu_finish) begin
                        state_reg     <= DONE;
                        cdb_valid_reg <= 1'b1;
                        cdb_data_reg  <= fu_res;
                        cdb_tag_reg   <= tag_reg;
                    end
`endif
                end
                DONE: begin
`ifdef FU_MUL_ARB_OVERLAP_EN
                    if (cdb_ready) begin
                        if (res_pending_reg) begin
                            cdb_data_reg    <= fu_res;
                            cdb_tag_reg     <= tag_reg;
                            res_pending_reg <= 1'b0;
                        end else begin
                            cdb_valid_reg <= 1'b0;
                            state_reg     <= IDLE;
                            busy_reg      <= 1'b0;
                        end
                    end else if (fu_en) begin
                        state_reg <= WAIT;
                    end
`else
                    if (cdb_ready) begin
                        cdb_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                        busy_reg      <= 1'b0;
                    end
`endif
                end
                default: begin
                    state_reg <= DRAIN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fu_mul_arbiter.sv
// Directed bench for fu_mul_arbiter with a behavioural 7-cycle multiplier model.
`timescale 1ns/1ps
module tb_fu_mul_arbiter;
    localparam int NREQ = 4;
    localparam int TAGW = 5;
    localparam int LAT  = 7;
`ifdef FU_MUL_ARB_OVERLAP_EN
    localparam logic [NREQ-1:0] HOLD_VALID = 4'b0000;
`else
    localparam logic [NREQ-1:0] HOLD_VALID = 4'b1111;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*32-1:0]   req_a;
    logic [NREQ*32-1:0]   req_b;
    logic [NREQ*TAGW-1:0] req_tag;
    logic                 fu_en;
    logic [31:0]          fu_a;
    logic [31:0]          fu_b;
    logic [31:0]          fu_res;
    logic                 fu_finish;
    logic                 cdb_valid;
    logic                 cdb_ready;
    logic [31:0]          cdb_data;
    logic [TAGW-1:0]      cdb_tag;
    logic                 busy;

    always #5 clk = ~clk;

    fu_mul_arbiter #(.NREQ(NREQ), .TAGW(TAGW), .LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .fu_en(fu_en), .fu_a(fu_a), .fu_b(fu_b),
        .fu_res(fu_res), .fu_finish(fu_finish),
        .cdb_valid(cdb_valid), .cdb_ready(cdb_ready),
        .cdb_data(cdb_data), .cdb_tag(cdb_tag), .busy(busy)
    );

    // Multiplier model: no reset, finish pulse LAT cycles after fu_en.
    logic [LAT-1:0] fu_sr = '0;
    logic [31:0]    fu_res_q = '0;
    always @(posedge clk) begin
        fu_sr <= {fu_sr[LAT-2:0], fu_en};
        if (fu_en) fu_res_q <= fu_a * fu_b;
    end
    assign fu_finish = fu_sr[LAT-1];
    assign fu_res    = fu_res_q;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [TAGW-1:0] t);
        req_a[32*i +: 32]     = a;
        req_b[32*i +: 32]     = b;
        req_tag[TAGW*i +: TAGW] = t;
    endtask

    task automatic wait_grant(input int limit, output int gc, output logic [NREQ-1:0] g);
        gc = -1;
        g  = '0;
        for (int n = 0; n < limit; n++) begin
            samp();
            if (fu_en) begin
                gc = cyc;
                g  = req_ready;
                $display("[TB] cycle %0d grant %b a=0x%0h b=0x%0h", cyc, req_ready, fu_a, fu_b);
                break;
            end
            step();
        end
        if (gc < 0) check("grant_timeout", 64'(fu_en), 64'd1);
    endtask

    task automatic wait_cdb(input int limit, output int fc);
        fc = -1;
        for (int n = 0; n < limit; n++) begin
            samp();
            if (cdb_valid) begin
                fc = cyc;
                $display("[TB] cycle %0d cdb data=0x%0h tag=%0d", cyc, cdb_data, cdb_tag);
                break;
            end
            step();
        end
        if (fc < 0) check("cdb_timeout", 64'(cdb_valid), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int gc, fc, prev;
        logic [NREQ-1:0] g;

        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_tag = '0; cdb_ready = 1'b0;
        set_req(0, 32'd3, 32'd5, 5'd2);
        step(); step();
        rst = 1'b0;
        req_valid = 4'b0001;

        // Reset state and the LAT+1 drain cycles with a request already waiting
        samp();
        check("rst_cdb_valid", 64'(cdb_valid), 64'd0);
        check("rst_cdb_data", 64'(cdb_data), 64'd0);
        check("rst_cdb_tag", 64'(cdb_tag), 64'd0);
        check("rst_busy", 64'(busy), 64'd1);
        check("drain_ready", 64'(req_ready), 64'd0);
        step();
        for (int i = 1; i < LAT + 1; i++) begin
            samp();
            check("drain_ready", 64'(req_ready), 64'd0);
            check("drain_fu_en", 64'(fu_en), 64'd0);
            step();
        end
        samp();
        check("first_ready", 64'(req_ready), 64'b0001);
        check("first_fu_en", 64'(fu_en), 64'd1);
        check("first_fu_a", 64'(fu_a), 64'd3);
        check("first_fu_b", 64'(fu_b), 64'd5);
        check("idle_busy", 64'(busy), 64'd0);
        gc = cyc;
        step();
        req_valid = '0;
        samp();
        check("wait_fu_a_zero", 64'(fu_a), 64'd0);
        step();
        wait_cdb(30, fc);
        check("first_latency", 64'(fc - gc), 64'(LAT + 1));
        check("first_data", 64'(cdb_data), 64'd15);
        check("first_tag", 64'(cdb_tag), 64'd2);

        // Hold in DONE with cdb_ready low
        for (int i = 0; i < NREQ; i++) set_req(i, 32'(100 + i), 32'(1 + i), 5'(8 + i));
        for (int i = 0; i < 10; i++) begin
            step();
            req_valid = HOLD_VALID;
            samp();
            check("hold_valid", 64'(cdb_valid), 64'd1);
            check("hold_data", 64'(cdb_data), 64'd15);
            check("hold_tag", 64'(cdb_tag), 64'd2);
            check("hold_ready", 64'(req_ready), 64'd0);
        end
        step();
        req_valid = '0;
        cdb_ready = 1'b1;
        samp();
        check("accept_cycle_valid", 64'(cdb_valid), 64'd1);
        step();
        cdb_ready = 1'b0;
        samp();
        check("after_accept_valid", 64'(cdb_valid), 64'd0);
        check("after_accept_busy", 64'(busy), 64'd0);

        // Round-robin from reset pointer with back-to-back accepts
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        req_valid = 4'b1111;
        cdb_ready = 1'b1;
        prev = 0;
        for (int k = 0; k < 5; k++) begin
            wait_grant(40, gc, g);
            check("rr_grant", 64'(g), 64'd1 << (k % 4));
            if (k > 0) check("rr_spacing", 64'(gc - prev), 64'(LAT + 2));
            prev = gc;
            step();
        end

        // Requester 2 drops out just before its turn
        wait_grant(40, gc, g);
        check("rr_grant1", 64'(g), 64'b0010);
        step();
        req_valid = 4'b1011;
        wait_grant(40, gc, g);
        check("skip_to_3", 64'(g), 64'b1000);
        step();
        req_valid = '0;
        wait_cdb(30, fc);
        check("req3_data", 64'(cdb_data), 64'd412);
        check("req3_tag", 64'(cdb_tag), 64'd11);
        check("rr_ptr_3", 64'(dut.rr_ptr_reg), 64'd3);
        step();
        req_valid = 4'b1001;
        wait_grant(40, gc, g);
        check("after_3_grant0", 64'(g), 64'b0001);

        // Reset three cycles after issue: op discarded, stale finish ignored
        step();
        req_valid = '0;
        step();
        step();
        rst = 1'b1;
        samp();
        check("rst_mid_valid", 64'(cdb_valid), 64'd0);
        for (int i = 0; i < 12; i++) begin
            step();
            rst = 1'b0;
            samp();
            check("rst_discard_valid", 64'(cdb_valid), 64'd0);
        end
        step();
        set_req(2, 32'hFFFF_FFFF, 32'd2, 5'd17);
        req_valid = 4'b0100;
        wait_grant(40, gc, g);
        check("post_rst_grant", 64'(g), 64'b0100);
        step();
        req_valid = '0;
        wait_cdb(30, fc);
        check("post_rst_data", 64'(cdb_data), 64'hFFFF_FFFE);
        check("post_rst_tag", 64'(cdb_tag), 64'd17);

`ifdef FU_MUL_ARB_OVERLAP_EN
        // Second op issued from DONE; its result queues behind the first
        step();
        cdb_ready = 1'b0;
        set_req(0, 32'd6, 32'd7, 5'd4);
        req_valid = 4'b0001;
        wait_grant(40, gc, g);
        check("ov_grant0", 64'(g), 64'b0001);
        step();
        req_valid = '0;
        wait_cdb(30, fc);
        check("ov_first_data", 64'(cdb_data), 64'd42);
        step();
        set_req(1, 32'd10, 32'd11, 5'd9);
        req_valid = 4'b0010;
        samp();
        check("ov_done_grant", 64'(req_ready), 64'b0010);
        check("ov_done_valid", 64'(cdb_valid), 64'd1);
        step();
        req_valid = 4'b0100;
        fc = -1;
        for (int n = 0; n < 20; n++) begin
            samp();
            if (dut.res_pending_reg) begin fc = n; break; end
            step();
        end
        check("ov_pending", 64'(dut.res_pending_reg), 64'd1);
        check("ov_hold_data", 64'(cdb_data), 64'd42);
        check("ov_hold_tag", 64'(cdb_tag), 64'd4);
        for (int i = 0; i < 3; i++) begin
            step();
            samp();
            check("ov_no_third", 64'(req_ready), 64'd0);
        end
        step();
        req_valid = '0;
        cdb_ready = 1'b1;
        step();
        cdb_ready = 1'b0;
        samp();
        check("ov_second_valid", 64'(cdb_valid), 64'd1);
        check("ov_second_data", 64'(cdb_data), 64'd110);
        check("ov_second_tag", 64'(cdb_tag), 64'd9);
        check("ov_pending_clr", 64'(dut.res_pending_reg), 64'd0);
        step();
        cdb_ready = 1'b1;
        step();
        cdb_ready = 1'b0;
        samp();
        check("ov_empty", 64'(cdb_valid), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
